// File: rtl/vga_timing.sv
// Free-running VGA raster timing generator: position counters, sync, blanking and strobes.
// Optional macro VGA_TIMING_FRAME_COUNT_EN adds an 8-bit frame counter output.
module vga_timing #(
    parameter int H_VIEW  = 640,
    parameter int H_FRONT = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BACK  = 48,
    parameter int V_VIEW  = 480,
    parameter int V_FRONT = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BACK  = 33,
    parameter int FETCH_H = 408
) (
    input  logic       clk,
    input  logic       reset,
    output logic       hsync,
    output logic       vsync,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       hmax,
    output logic       vmax,
    output logic       visible,
    output logic       line_fetch,
    output logic       frame_start
`ifdef VGA_TIMING_FRAME_COUNT_EN
    ,
    output logic [7:0] frame_count
`endif
);

    localparam int H_TOTAL = H_VIEW + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VIEW + V_FRONT + V_SYNC + V_BACK;

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024 || FETCH_H >= H_TOTAL) begin : g_bad_params
            $error("vga_timing: totals must not exceed 1024 and FETCH_H must be below H_TOTAL");
        end
    endgenerate

    // Decode thresholds are 11 bits wide so a sync end equal to 1024 still compares correctly.
    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS    = 11'(H_VIEW);
    localparam logic [10:0] V_VIS    = 11'(V_VIEW);
    localparam logic [10:0] HS_START = 11'(H_VIEW + H_FRONT);
    localparam logic [10:0] HS_END   = 11'(H_VIEW + H_FRONT + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_VIEW + V_FRONT);
    localparam logic [10:0] VS_END   = 11'(V_VIEW + V_FRONT + V_SYNC);
    localparam logic [10:0] FETCH    = 11'(FETCH_H);
    localparam logic        FETCH_AT_ZERO = (FETCH_H == 0);

    logic [9:0] hpos_q, hpos_d;
    logic [9:0] vpos_q, vpos_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       hmax_q, hmax_d;
    logic       vmax_q, vmax_d;
    logic       visible_q, visible_d;
    logic       line_fetch_q, line_fetch_d;
    logic       frame_start_q, frame_start_d;
    logic [10:0] h_next;
    logic [10:0] v_next;

    // Flags are decoded from the next position so they line up with hpos/vpos with no lag.
    // NOTE: every always_comb output gets a default first, so no path can leave a latch.
    always_comb begin
        hpos_d = hpos_q + 10'd1;
        vpos_d = vpos_q;
        if (hmax_q) begin
            hpos_d = 10'd0;
            vpos_d = vmax_q ? 10'd0 : vpos_q + 10'd1;
        end

        h_next = {1'b0, hpos_d};
        v_next = {1'b0, vpos_d};

        hsync_d       = (h_next >= HS_START) && (h_next < HS_END);
        vsync_d       = (v_next >= VS_START) && (v_next < VS_END);
        hmax_d        = (h_next == H_LAST);
        vmax_d        = (v_next == V_LAST);
        visible_d     = (h_next < H_VIS) && (v_next < V_VIS);
        line_fetch_d  = (h_next == FETCH);
        frame_start_d = (h_next == 11'd0) && (v_next == 11'd0);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            hpos_q        <= 10'd0;
            vpos_q        <= 10'd0;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            hmax_q        <= 1'b0;
            vmax_q        <= 1'b0;
            visible_q     <= 1'b1;
            line_fetch_q  <= FETCH_AT_ZERO;
            frame_start_q <= 1'b1;
        end else begin
            hpos_q        <= hpos_d;
            vpos_q        <= vpos_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            hmax_q        <= hmax_d;
            vmax_q        <= vmax_d;
            visible_q     <= visible_d;
            line_fetch_q  <= line_fetch_d;
            frame_start_q <= frame_start_d;
        end
    end

`ifdef VGA_TIMING_FRAME_COUNT_EN
    logic [7:0] frame_count_q, frame_count_d;

    // Advances on the same edge that both counters wrap, coincident with frame_start.
    always_comb begin
        frame_count_d = frame_count_q;
        if (hmax_q && vmax_q) begin
            frame_count_d = frame_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_count_q <= 8'd0;
        end else begin
            frame_count_q <= frame_count_d;
        end
    end

    assign frame_count = frame_count_q;
`endif

    assign hpos        = hpos_q;
    assign vpos        = vpos_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign hmax        = hmax_q;
    assign vmax        = vmax_q;
    assign visible     = visible_q;
    assign line_fetch  = line_fetch_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing.sv
// Scoreboard bench for vga_timing: a default-timing instance checks one line and mid-line reset,
// a reduced-timing instance checks whole frames, frame-level counts and mid-frame reset.
module tb_vga_timing;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_a, reset_b;
    logic       hs_a, vs_a, hm_a, vm_a, vis_a, lf_a, fs_a;
    logic [9:0] hp_a, vp_a;
    logic       hs_b, vs_b, hm_b, vm_b, vis_b, lf_b, fs_b;
    logic [9:0] hp_b, vp_b;
`ifdef VGA_TIMING_FRAME_COUNT_EN
    logic [7:0] fc_a, fc_b;
`endif

    vga_timing dut_a (
        .clk(clk), .reset(reset_a), .hsync(hs_a), .vsync(vs_a), .hpos(hp_a), .vpos(vp_a),
        .hmax(hm_a), .vmax(vm_a), .visible(vis_a), .line_fetch(lf_a), .frame_start(fs_a)
`ifdef VGA_TIMING_FRAME_COUNT_EN
        , .frame_count(fc_a)
`endif
    );

    // Reduced raster: 15 pixels x 10 lines = 150 cycles per frame.
    // hsync at hpos 10..12, visible hpos<8 and vpos<6, vsync on lines 7..8, fetch at hpos 5.
    vga_timing #(
        .H_VIEW(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VIEW(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .FETCH_H(5)
    ) dut_b (
        .clk(clk), .reset(reset_b), .hsync(hs_b), .vsync(vs_b), .hpos(hp_b), .vpos(vp_b),
        .hmax(hm_b), .vmax(vm_b), .visible(vis_b), .line_fetch(lf_b), .frame_start(fs_b)
`ifdef VGA_TIMING_FRAME_COUNT_EN
        , .frame_count(fc_b)
`endif
    );

    // flags = {hsync, vsync, hmax, vmax, visible, line_fetch, frame_start}
    typedef struct {
        string      name;
        bit         dut_b;
        logic [9:0] h;
        logic [9:0] v;
        logic [6:0] flags;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input int got, input int expv);
        n_checks++;
        if (got == expv) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, expv);
    endtask

    task automatic push(input string name, input bit b, input int h, input int v,
                        input logic [6:0] f);
        exp_t e;
        e.name  = name;
        e.dut_b = b;
        e.h     = 10'(h);
        e.v     = 10'(v);
        e.flags = f;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: each cycle's outputs are compared against whatever the stimulus queued for it.
    exp_t        mon_e;
    logic [26:0] mon_got, mon_want;
    always @(negedge clk) begin
        while (sb.size() != 0) begin
            mon_e    = sb.pop_front();
            mon_want = {mon_e.h, mon_e.v, mon_e.flags};
            mon_got  = mon_e.dut_b ? {hp_b, vp_b, hs_b, vs_b, hm_b, vm_b, vis_b, lf_b, fs_b}
                                   : {hp_a, vp_a, hs_a, vs_a, hm_a, vm_a, vis_a, lf_a, fs_a};
            n_checks++;
            if (mon_got === mon_want) n_pass++;
            else $display("FAIL %s: got hpos=%0d vpos=%0d flags=%b, expected hpos=%0d vpos=%0d flags=%b",
                          mon_e.name, mon_got[26:17], mon_got[16:7], mon_got[6:0],
                          mon_want[26:17], mon_want[16:7], mon_want[6:0]);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

    int hs_cnt, vs_cnt, vm_cnt, hmvm_cnt, lf_cnt, lf_bad, vis_cnt, fs_cnt, hm_cnt;
    int fs_total, gap_err, pos_err, last_fs, fc_err;
    int h, v;

    initial begin
        reset_a = 1'b1;
        reset_b = 1'b1;

        // ---- default timing: reset held 3 cycles, then one full line ----
        tick();
        push("a_reset_first_edge", 0, 0, 0, 7'b0000101);
        tick();
        tick();
        push("a_reset_held", 0, 0, 0, 7'b0000101);
        reset_a = 1'b0;

        hs_cnt = 0; vis_cnt = 0; hm_cnt = 0; lf_cnt = 0;
        for (int k = 0; k < 800; k++) begin
            if (k > 0) tick();
            hs_cnt  += int'(hs_a);
            vis_cnt += int'(vis_a);
            hm_cnt  += int'(hm_a);
            lf_cnt  += int'(lf_a);
            case (k)
                1:   push("a_first_increment", 0, 1,   0, 7'b0000100);
                407: push("a_before_fetch",    0, 407, 0, 7'b0000100);
                408: push("a_fetch",           0, 408, 0, 7'b0000110);
                409: push("a_after_fetch",     0, 409, 0, 7'b0000100);
                639: push("a_last_visible",    0, 639, 0, 7'b0000100);
                640: push("a_first_blank",     0, 640, 0, 7'b0000000);
                655: push("a_before_hsync",    0, 655, 0, 7'b0000000);
                656: push("a_hsync_rise",      0, 656, 0, 7'b1000000);
                751: push("a_hsync_last",      0, 751, 0, 7'b1000000);
                752: push("a_hsync_fall",      0, 752, 0, 7'b0000000);
                798: push("a_before_hmax",     0, 798, 0, 7'b0000000);
                799: push("a_hmax",            0, 799, 0, 7'b0010000);
                default: ;
            endcase
        end
        check("a_hsync_cycles_per_line", hs_cnt, 96);
        check("a_visible_cycles_line0", vis_cnt, 640);
        check("a_hmax_cycles_per_line", hm_cnt, 1);
        check("a_line_fetch_per_line", lf_cnt, 1);
        tick();
        push("a_line_wrap", 0, 0, 1, 7'b0000100);

        // Reset mid-line while hsync is high.
        repeat (700) tick();
        push("a_hsync_before_reset", 0, 700, 1, 7'b1000000);
        reset_a = 1'b1;
        tick();
        push("a_reset_midline", 0, 0, 0, 7'b0000101);
        reset_a = 1'b0;
        tick();
        push("a_after_midline_reset", 0, 1, 0, 7'b0000100);

        // ---- reduced timing: 258 frames from reset ----
        tick();
        push("b_reset", 1, 0, 0, 7'b0000101);
        reset_b = 1'b0;

        hs_cnt = 0; vs_cnt = 0; vm_cnt = 0; hmvm_cnt = 0; lf_cnt = 0; lf_bad = 0;
        vis_cnt = 0; fs_cnt = 0; fs_total = 0; gap_err = 0; pos_err = 0; last_fs = -1;
        fc_err = 0;
        for (int k = 0; k <= 258 * 150; k++) begin
            if (k > 0) tick();
            h = k % 15;
            v = (k / 15) % 10;
            if (int'(hp_b) != h || int'(vp_b) != v) pos_err++;
            if (k < 150) begin
                hs_cnt   += int'(hs_b);
                vs_cnt   += int'(vs_b);
                vm_cnt   += int'(vm_b);
                hmvm_cnt += int'(hm_b && vm_b);
                lf_cnt   += int'(lf_b);
                vis_cnt  += int'(vis_b);
                fs_cnt   += int'(fs_b);
            end
            if (lf_b && hp_b != 10'd5) lf_bad++;
            if (fs_b) begin
                fs_total++;
                if (last_fs >= 0 && k - last_fs != 150) gap_err++;
                last_fs = k;
            end
`ifdef VGA_TIMING_FRAME_COUNT_EN
            if (int'(fc_b) != (k / 150) % 256) fc_err++;
            if (k % 150 == 0 && (k / 150 < 3 || k / 150 >= 255))
                check("b_frame_count_at_frame_start", int'(fc_b), (k / 150) % 256);
`endif
            case (k)
                5:   push("b_fetch_visible_line", 1, 5,  0, 7'b0000110);
                7:   push("b_last_visible",       1, 7,  0, 7'b0000100);
                8:   push("b_first_blank",        1, 8,  0, 7'b0000000);
                10:  push("b_hsync_rise",         1, 10, 0, 7'b1000000);
                12:  push("b_hsync_last",         1, 12, 0, 7'b1000000);
                13:  push("b_hsync_fall",         1, 13, 0, 7'b0000000);
                14:  push("b_hmax",               1, 14, 0, 7'b0010000);
                15:  push("b_line_wrap",          1, 0,  1, 7'b0000100);
                90:  push("b_first_vblank_line",  1, 0,  6, 7'b0000000);
                95:  push("b_fetch_in_vblank",    1, 5,  6, 7'b0000010);
                105: push("b_vsync_rise",         1, 0,  7, 7'b0100000);
                134: push("b_vsync_last_pixel",   1, 14, 8, 7'b0110000);
                135: push("b_vsync_fall_vmax",    1, 0,  9, 7'b0001000);
                149: push("b_hmax_and_vmax",      1, 14, 9, 7'b0011000);
                150: push("b_frame_wrap",         1, 0,  0, 7'b0000101);
                151: push("b_after_frame_wrap",   1, 1,  0, 7'b0000100);
                default: ;
            endcase
        end
        check("b_hsync_cycles_per_frame", hs_cnt, 30);
        check("b_vsync_cycles_per_frame", vs_cnt, 30);
        check("b_vmax_cycles_per_frame", vm_cnt, 15);
        check("b_hmax_and_vmax_cycles", hmvm_cnt, 1);
        check("b_line_fetch_per_frame", lf_cnt, 10);
        check("b_line_fetch_off_position", lf_bad, 0);
        check("b_visible_cycles_per_frame", vis_cnt, 48);
        check("b_frame_start_per_frame", fs_cnt, 1);
        check("b_frame_start_total", fs_total, 259);
        check("b_frame_period_errors", gap_err, 0);
        check("b_position_errors", pos_err, 0);
`ifdef VGA_TIMING_FRAME_COUNT_EN
        check("b_frame_count_errors", fc_err, 0);
`endif

        // Reset mid-frame while both syncs are high.
        repeat (8 * 15 + 11) tick();
        push("b_syncs_before_reset", 1, 11, 8, 7'b1100000);
        reset_b = 1'b1;
        tick();
        push("b_reset_midframe", 1, 0, 0, 7'b0000101);
`ifdef VGA_TIMING_FRAME_COUNT_EN
        check("b_frame_count_after_reset", int'(fc_b), 0);
`endif
        reset_b = 1'b0;
        tick();
        push("b_after_midframe_reset", 1, 1, 0, 7'b0000100);

        tick();
        tick();
        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
